fir_load_seq: RTL and testbench

FIR_LOAD_SEQ -- requirements
Module: fir_load_seq

---
 rtl/fir_load_seq.sv | 92 +++++++++
 tb/tb_fir_load_seq.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_load_seq.sv
// Streams coefficient or data words into a FIR controller, issuing write strobes with sequential addresses.
// Latency 1 from transfer to strobe; s_ready drops outside COEF/DATA or while abort is asserted.
module fir_load_seq #(
    parameter int NCOEF = 64,
    parameter int NDATA = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_c,
    input  logic        start_d,
    input  logic        abort,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic        cload,
    output logic        dload,
    output logic [13:0] addr,
    output logic [15:0] din,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COEF = 2'd1,
        DATA = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam logic [13:0] C_LAST = 14'(NCOEF - 1);
    localparam logic [13:0] D_LAST = 14'(NDATA - 1);

    state_t      state;
    logic [13:0] cnt;
    logic        loading;
    logic        xfer;
    logic        last;

    assign loading = (state == COEF) || (state == DATA);
    assign busy    = loading;
    assign s_ready = loading && !abort;
    assign xfer    = s_valid && s_ready;
    assign last    = (state == COEF) ? (cnt == C_LAST) : (cnt == D_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cload <= 1'b0;
            dload <= 1'b0;
            addr  <= '0;
            din   <= '0;
            done  <= 1'b0;
        end else begin
            cload <= 1'b0;
            dload <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_c) begin
                        state <= COEF;
                        cnt   <= '0;
                    end else if (start_d) begin
                        state <= DATA;
                        cnt   <= '0;
                    end
                end
                COEF, DATA: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (xfer) begin
                        din   <= s_data;
                        addr  <= cnt;
                        cload <= (state == COEF);
                        dload <= (state == DATA);
                        // Counter parks at the limit so addr can never wrap.
                        if (last) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 14'd1;
                        end
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_load_seq.sv
// Scoreboard bench for fir_load_seq: stimulus pushes expected strobes, negedge monitors pop and compare.
module tb_fir_load_seq;

    typedef struct {
        logic        c;
        logic        d;
        logic [13:0] a;
        logic [15:0] dat;
        logic        dn;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_c, start_d, start_c2, start_d2, abort, s_valid;
    logic [15:0] s_data;
    logic        s_ready1, cload1, dload1, busy1, done1;
    logic [13:0] addr1;
    logic [15:0] din1;
    logic        s_ready2, cload2, dload2, busy2, done2;
    logic [13:0] addr2;
    logic [15:0] din2;

    int tests = 0;
    int fails = 0;
    exp_t q1[$];
    exp_t q2[$];
    logic [13:0] last_a1 = '0, last_a2 = '0;
    logic [15:0] last_d1 = '0, last_d2 = '0;

    always #5 clk = ~clk;

    fir_load_seq #(.NCOEF(64), .NDATA(10000)) dut1 (
        .clk(clk), .rst(rst), .start_c(start_c), .start_d(start_d), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready1), .cload(cload1),
        .dload(dload1), .addr(addr1), .din(din1), .busy(busy1), .done(done1)
    );

    fir_load_seq #(.NCOEF(1), .NDATA(2)) dut2 (
        .clk(clk), .rst(rst), .start_c(start_c2), .start_d(start_d2), .abort(abort),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready2), .cload(cload2),
        .dload(dload2), .addr(addr2), .din(din2), .busy(busy2), .done(done2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic c, input logic [13:0] a, input logic [15:0] dat,
                                input logic dn);
        exp_t e;
        e.c = c;
        e.d = !c;
        e.a = a;
        e.dat = dat;
        e.dn = dn;
        return e;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            last_a1 = '0;
            last_d1 = '0;
        end else begin
            check("m1_excl", {31'd0, cload1 && dload1}, 32'd0);
            if (cload1 || dload1) begin
                tests++;
                if (q1.size() == 0) begin
                    fails++;
                    $display("FAIL m1_unexpected_strobe: addr %0d din %0h with nothing expected", addr1, din1);
                end else begin
                    exp_t e;
                    e = q1.pop_front();
                    check("m1_cload", cload1, e.c);
                    check("m1_dload", dload1, e.d);
                    check("m1_addr", addr1, e.a);
                    check("m1_din", din1, e.dat);
                    check("m1_done", done1, e.dn);
                    last_a1 = e.a;
                    last_d1 = e.dat;
                end
            end else begin
                check("m1_done_idle", done1, 0);
                check("m1_hold_addr", addr1, last_a1);
                check("m1_hold_din", din1, last_d1);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            last_a2 = '0;
            last_d2 = '0;
        end else begin
            if (cload2 || dload2) begin
                tests++;
                if (q2.size() == 0) begin
                    fails++;
                    $display("FAIL m2_unexpected_strobe: addr %0d din %0h with nothing expected", addr2, din2);
                end else begin
                    exp_t e;
                    e = q2.pop_front();
                    check("m2_cload", cload2, e.c);
                    check("m2_dload", dload2, e.d);
                    check("m2_addr", addr2, e.a);
                    check("m2_din", din2, e.dat);
                    check("m2_done", done2, e.dn);
                    last_a2 = e.a;
                    last_d2 = e.dat;
                end
            end else begin
                check("m2_done_idle", done2, 0);
                check("m2_hold_addr", addr2, last_a2);
                check("m2_hold_din", din2, last_d2);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start_c = 0; start_d = 0; start_c2 = 0; start_d2 = 0;
        abort = 0; s_valid = 0; s_data = '0;
        #1;
        check("rst_cload", cload1, 0);
        check("rst_dload", dload1, 0);
        check("rst_addr", addr1, 0);
        check("rst_din", din1, 0);
        check("rst_done", done1, 0);
        check("rst_busy", busy1, 0);
        check("rst_s_ready", s_ready1, 0);
        tick(); tick();
        rst = 1'b0;
        tick();

        // Plain coefficient load, s_data=1 throughout.
        start_c = 1; tick(); start_c = 0;
        check("coef_busy", busy1, 1);
        for (int i = 0; i < 64; i++) begin
            s_valid = 1; s_data = 16'd1; #1;
            check("coef_s_ready", s_ready1, 1);
            q1.push_back(mk(1'b1, 14'(i), 16'd1, i == 63));
            tick();
        end
        s_valid = 0;
        check("coef_done_pulse", done1, 1);
        check("coef_fin_busy", busy1, 0);
        check("coef_fin_s_ready", s_ready1, 0);
        tick();
        check("coef_done_single", done1, 0);
        check("coef_idle_busy", busy1, 0);

        // Coefficient load aborted on word 20.
        start_c = 1; tick(); start_c = 0;
        for (int i = 0; i < 20; i++) begin
            s_valid = 1; s_data = 16'h0C00 + 16'(i); #1;
            q1.push_back(mk(1'b1, 14'(i), 16'h0C00 + 16'(i), 1'b0));
            tick();
        end
        s_valid = 1; s_data = 16'h0C14; abort = 1; #1;
        check("abort_s_ready", s_ready1, 0);
        tick();
        abort = 0; s_valid = 0;
        check("abort_idle", busy1, 0);
        check("abort_no_done", done1, 0);

        // Both starts together take COEF; a start_d during the load is dropped.
        start_c = 1; start_d = 1; tick(); start_c = 0; start_d = 0;
        check("both_busy", busy1, 1);
        for (int i = 0; i < 64; i++) begin
            s_valid = 1; s_data = 16'h7700 + 16'(i); start_d = (i == 30); #1;
            q1.push_back(mk(1'b1, 14'(i), 16'h7700 + 16'(i), i == 63));
            tick();
            if (i == 40) check("both_busy_mid", busy1, 1);
        end
        s_valid = 0; start_d = 0;
        tick(); tick();
        check("start_d_not_queued", busy1, 0);

        // Data load with s_valid alternating; gap words carry junk.
        start_d = 1; tick(); start_d = 0;
        for (int i = 0; i < 10000; i++) begin
            s_valid = 1; s_data = 16'(i); #1;
            check("data_s_ready", s_ready1, 1);
            q1.push_back(mk(1'b0, 14'(i), 16'(i), i == 9999));
            tick();
            if (i != 9999) begin
                s_valid = 0; s_data = ~16'(i);
                tick();
            end
        end
        s_valid = 0;
        check("data_done_pulse", done1, 1);
        tick();
        check("data_idle", busy1, 0);

        // Reset mid data load right after the addr=500 strobe.
        start_d = 1; tick(); start_d = 0;
        for (int i = 0; i <= 500; i++) begin
            s_valid = 1; s_data = 16'h4000 + 16'(i); #1;
            q1.push_back(mk(1'b0, 14'(i), 16'h4000 + 16'(i), 1'b0));
            tick();
        end
        s_valid = 0;
        @(negedge clk); #1;
        rst = 1; #1;
        check("mid_rst_dload", dload1, 0);
        check("mid_rst_cload", cload1, 0);
        check("mid_rst_addr", addr1, 0);
        check("mid_rst_din", din1, 0);
        check("mid_rst_done", done1, 0);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_s_ready", s_ready1, 0);
        tick(); tick();
        rst = 0;
        tick();
        check("post_rst_idle", busy1, 0);
        start_d = 1; tick(); start_d = 0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1; s_data = 16'h00A0 + 16'(i); #1;
            q1.push_back(mk(1'b0, 14'(i), 16'h00A0 + 16'(i), 1'b0));
            tick();
        end
        abort = 1; #1;
        check("post_rst_abort_s_ready", s_ready1, 0);
        tick();
        abort = 0; s_valid = 0;
        check("post_rst_abort_idle", busy1, 0);
        tick();

        // Single-word coefficient load, then a two-word data load.
        start_c2 = 1; tick(); start_c2 = 0;
        s_valid = 1; s_data = 16'hABCD; #1;
        check("n1_s_ready", s_ready2, 1);
        q2.push_back(mk(1'b1, 14'd0, 16'hABCD, 1'b1));
        tick();
        s_valid = 0;
        check("n1_done", done2, 1);
        check("n1_fin_busy", busy2, 0);
        check("n1_fin_s_ready", s_ready2, 0);
        tick();
        check("n1_done_once", done2, 0);
        check("n1_idle_busy", busy2, 0);
        start_d2 = 1; tick(); start_d2 = 0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1; s_data = 16'd5 + 16'(i); #1;
            q2.push_back(mk(1'b0, 14'(i), 16'd5 + 16'(i), i == 1));
            tick();
        end
        s_valid = 0;
        tick(); tick();
        check("n2_idle_busy", busy2, 0);

        check("q1_drained", q1.size(), 0);
        check("q2_drained", q2.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
